// File: rtl/ir_dispatch_q.sv
// EBOX instruction register fed by a prefetch FIFO, plus a diagnostic-writable
// dispatch RAM whose A/B/J fields for the current IR are registered one cycle after a pop.
module ir_dispatch_q #(
    parameter int IR_W       = 13,
    parameter int DRAM_W     = 15,
    parameter int DRAM_DEPTH = 512,
    parameter int QDEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IR_W-1:0]               in_word,
    output logic                          in_ready,
    input  logic                          load_ir,
    input  logic                          flush,
    input  logic                          en_io_jrst,
    input  logic                          en_ac,
    output logic [IR_W-1:0]               ir,
    output logic [3:0]                    ac,
    output logic                          ir_valid,
    output logic                          stall,
    output logic [2:0]                    dram_a,
    output logic [2:0]                    dram_b,
    output logic [DRAM_W-8:0]             dram_j,
    output logic                          dram_valid,
    output logic                          par_err,
    input  logic                          diag_we,
    input  logic [$clog2(DRAM_DEPTH)-1:0] diag_addr,
    input  logic [DRAM_W-1:0]             diag_wdata,
    input  logic                          diag_clr_err,
    output logic [$clog2(QDEPTH):0]       q_count
);

    localparam int DA = $clog2(DRAM_DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int JW = DRAM_W - 7;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    logic [IR_W-1:0]   q_mem [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [IR_W-1:0]   ir_q, head;
    logic [3:0]        ac_q;
    logic              ir_valid_q, stall_q;
    logic              q_empty, q_full, push, pop;

    state_t            state_q, state_d;
    logic              lookup_done;
    logic [DRAM_W-1:0] dram_mem [DRAM_DEPTH];
    logic [DRAM_W-1:0] entry;
    logic [DA-1:0]     dram_addr;
    logic [8:0]        opcode;
    logic [3:0]        ac_field;
    logic              io_mode, jrst;
    logic [JW-1:0]     j_sub;
    logic [2:0]        a_q, b_q;
    logic [JW-1:0]     j_q;
    logic              par_err_q;

    // Flush outranks both queue operations, so a word offered or popped that cycle is lost.
    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == FULL);
    assign push    = in_valid & ~q_full & ~flush;
    assign pop     = load_ir & ~q_empty & ~flush;
    assign head    = q_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= in_word;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            ac_q       <= '0;
            ir_valid_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= load_ir & q_empty;
            if (pop) begin
                ir_q       <= head;
                ac_q       <= en_ac ? head[IR_W-10 -: 4] : 4'd0;
                ir_valid_q <= 1'b1;
            end
        end
    end

    // IR bit 0 is the vector MSB: opcode is the top nine bits, AC the next four.
    assign opcode   = ir_q[IR_W-1 -: 9];
    assign ac_field = ir_q[IR_W-10 -: 4];
    assign io_mode  = (opcode[8:6] == 3'b111) & en_io_jrst;
    assign jrst     = (opcode == 9'o254) & en_io_jrst;

    always_comb begin
        dram_addr = opcode;
        if (io_mode) begin
            dram_addr = {3'b111, {opcode[1:0], ac_field[3]} | {3{&opcode[5:2]}}, ac_field[2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (diag_we) begin
            dram_mem[diag_addr] <= diag_wdata;
        end
    end

    assign entry = dram_mem[dram_addr];

    always_comb begin
        j_sub = entry[JW-1:0];
        if (jrst) begin
            j_sub[3:0] = ac_field;
        end
    end

    // A diag write steals the RAM port, so READ retries; any pop restarts the lookup.
    always_comb begin
        state_d     = state_q;
        lookup_done = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else if (pop) begin
            state_d = S_READ;
        end else begin
            case (state_q)
                S_READ: begin
                    if (!diag_we) begin
                        state_d     = S_DONE;
                        lookup_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            j_q <= '0;
        end else if (lookup_done) begin
            a_q <= entry[DRAM_W-1 -: 3];
            b_q <= entry[DRAM_W-4 -: 3];
            j_q <= j_sub;
        end
    end

    // Entries are stored with odd parity; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (lookup_done && !(^entry)) begin
            par_err_q <= 1'b1;
        end else if (diag_clr_err) begin
            par_err_q <= 1'b0;
        end
    end

    assign in_ready   = ~q_full;
    assign q_count    = count_q;
    assign ir         = ir_q;
    assign ac         = ac_q;
    assign ir_valid   = ir_valid_q;
    assign stall      = stall_q;
    assign dram_a     = a_q;
    assign dram_b     = b_q;
    assign dram_j     = j_q;
    assign dram_valid = (state_q == S_DONE);
    assign par_err    = par_err_q;

endmodule

// File: tb/tb_ir_dispatch_q.sv
// Self-checking bench for ir_dispatch_q: directed scenarios with fixed expectations,
// then randomized traffic compared against a queue-based behavioural model.
module tb_ir_dispatch_q;

    logic        clk = 1'b0;
    logic        rst, in_valid, load_ir, flush, en_io_jrst, en_ac;
    logic        diag_we, diag_clr_err;
    logic [12:0] in_word;
    logic [8:0]  diag_addr;
    logic [14:0] diag_wdata;
    logic        in_ready, ir_valid, stall, dram_valid, par_err;
    logic [12:0] ir;
    logic [3:0]  ac;
    logic [2:0]  dram_a, dram_b, q_count;
    logic [7:0]  dram_j;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [12:0] m_q[$];
    logic [14:0] m_mem[512];
    logic [12:0] m_ir;
    logic [3:0]  m_ac;
    logic        m_irv, m_stall, m_pend, m_dv, m_perr;
    logic [2:0]  m_a, m_b;
    logic [7:0]  m_j;

    ir_dispatch_q dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .load_ir(load_ir), .flush(flush), .en_io_jrst(en_io_jrst), .en_ac(en_ac),
        .ir(ir), .ac(ac), .ir_valid(ir_valid), .stall(stall),
        .dram_a(dram_a), .dram_b(dram_b), .dram_j(dram_j), .dram_valid(dram_valid),
        .par_err(par_err), .diag_we(diag_we), .diag_addr(diag_addr), .diag_wdata(diag_wdata),
        .diag_clr_err(diag_clr_err), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] make_entry(input logic [2:0] a, input logic [2:0] b, input logic [7:0] j);
        logic p;
        p = ~(^{a, b, j});
        return {a, b, p, j};
    endfunction

    function automatic logic [8:0] spec_addr(input logic [12:0] w, input logic io_en);
        logic [0:12] s;
        s = w;
        if (io_en && s[0:2] == 3'b111) return {3'b111, s[7:9] | {3{&s[3:6]}}, s[10:12]};
        return s[0:8];
    endfunction

    function automatic logic [7:0] exp_j(input logic [14:0] e, input logic [12:0] w, input logic io_en);
        logic [0:12] s;
        logic [7:0]  j;
        s = w;
        j = e[7:0];
        if (io_en && s[0:8] == 9'o254) j[3:0] = s[9:12];
        return j;
    endfunction

    // Advance the model across the coming edge using the inputs currently driven.
    task automatic model_step();
        logic [12:0] w;
        logic [14:0] e;
        logic        set_err, full, empty, do_push, do_pop;
        full  = (m_q.size() == 4);
        empty = (m_q.size() == 0);
        if (rst) begin
            m_q.delete();
            m_ir = '0; m_ac = '0; m_irv = 0; m_stall = 0; m_pend = 0; m_dv = 0;
            m_perr = 0; m_a = '0; m_b = '0; m_j = '0;
        end else begin
            do_push = in_valid && !full && !flush;
            do_pop  = load_ir && !empty && !flush;
            set_err = 0;
            m_stall = load_ir && empty;
            if (flush) begin
                m_q.delete();
                m_pend = 0;
                m_dv   = 0;
            end else begin
                if (m_pend && !do_pop && !diag_we) begin
                    e       = m_mem[spec_addr(m_ir, en_io_jrst)];
                    m_a     = e[14:12];
                    m_b     = e[11:9];
                    m_j     = exp_j(e, m_ir, en_io_jrst);
                    set_err = ~(^e);
                    m_pend  = 0;
                    m_dv    = 1;
                end
                if (do_pop) begin
                    w      = m_q.pop_front();
                    m_ir   = w;
                    m_ac   = en_ac ? w[3:0] : 4'h0;
                    m_irv  = 1;
                    m_pend = 1;
                    m_dv   = 0;
                end
                if (do_push) m_q.push_back(in_word);
            end
            if (set_err) m_perr = 1;
            else if (diag_clr_err) m_perr = 0;
        end
        if (diag_we) m_mem[diag_addr] = diag_wdata;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; load_ir = 0; flush = 0; diag_we = 0; diag_clr_err = 0;
    endtask

    task automatic diag_write(input logic [8:0] addr, input logic [14:0] data);
        diag_we = 1; diag_addr = addr; diag_wdata = data;
        cycle();
        diag_we = 0;
    endtask

    // Push one word into an empty queue, pop it, then give the lookup one quiet cycle.
    task automatic run_lookup(input logic [12:0] w);
        in_valid = 1; in_word = w;
        cycle();
        in_valid = 0; load_ir = 1;
        cycle();
        load_ir = 0;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        en_io_jrst = 0; en_ac = 1; in_word = '0; diag_addr = '0; diag_wdata = '0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        tests++; if (q_count !== 3'd0)  begin fails++; $display("[TB] FAIL reset_q_count got=%0d exp=0", q_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (ir !== 13'd0 || ac !== 4'd0 || ir_valid !== 1'b0)
            begin fails++; $display("[TB] FAIL reset_ir got=%o/%h/%b exp=0/0/0", ir, ac, ir_valid); end
        tests++; if (dram_valid !== 1'b0 || par_err !== 1'b0 || stall !== 1'b0)
            begin fails++; $display("[TB] FAIL reset_flags got dv=%b pe=%b st=%b exp=0", dram_valid, par_err, stall); end
        tests++; if ({dram_a, dram_b, dram_j} !== 14'd0)
            begin fails++; $display("[TB] FAIL reset_dram got=%h exp=0", {dram_a, dram_b, dram_j}); end
    endtask

    task automatic preload();
        for (int i = 0; i < 512; i++) begin
            diag_write(9'(i), make_entry(3'($urandom), 3'($urandom), 8'($urandom)));
        end
    endtask

    task automatic test_basic_lookup();
        diag_write(9'o200, make_entry(3'd3, 3'd5, 8'h5A));
        in_valid = 1; in_word = {9'o200, 4'h0};
        cycle();
        in_valid = 0; load_ir = 1;
        cycle();
        load_ir = 0;
        tests++; if (ir !== {9'o200, 4'h0} || ir_valid !== 1'b1)
            begin fails++; $display("[TB] FAIL basic_ir got=%o v=%b exp=%o v=1", ir, ir_valid, {9'o200, 4'h0}); end
        tests++; if (dram_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_dv_early got=%b exp=0", dram_valid); end
        cycle();
        tests++; if (dram_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_dv got=%b exp=1", dram_valid); end
        tests++; if (dram_a !== 3'd3 || dram_b !== 3'd5 || dram_j !== 8'h5A)
            begin fails++; $display("[TB] FAIL basic_fields got=%0d/%0d/%h exp=3/5/5a", dram_a, dram_b, dram_j); end
    endtask

    task automatic test_fill_wrap();
        logic [12:0] seq[12];
        int n_in, n_out, cnt;
        for (int i = 0; i < 12; i++) seq[i] = 13'($urandom);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_word = seq[i];
            cycle();
        end
        n_in = 4; n_out = 0; cnt = 4;
        tests++; if (in_ready !== 1'b0 || q_count !== 3'd4)
            begin fails++; $display("[TB] FAIL full_flags got rdy=%b cnt=%0d exp rdy=0 cnt=4", in_ready, q_count); end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1; in_word = seq[n_in]; load_ir = 1;
            cycle();
            if (cnt < 4) n_in++;
            else cnt--;
            tests++; if (q_count !== 3'(cnt) || ir !== seq[n_out])
                begin fails++; $display("[TB] FAIL wrap_%0d got cnt=%0d ir=%o exp cnt=%0d ir=%o", k, q_count, ir, cnt, seq[n_out]); end
            n_out++;
        end
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            load_ir = 1;
            cycle();
            tests++; if (ir !== seq[n_out])
                begin fails++; $display("[TB] FAIL drain_%0d got=%o exp=%o", k, ir, seq[n_out]); end
            n_out++;
        end
        load_ir = 0;
        cycle();
    endtask

    task automatic test_io_jrst();
        en_io_jrst = 1;
        diag_write(9'o700, make_entry(3'd7, 3'd1, 8'hC3));
        diag_write(9'o770, make_entry(3'd4, 3'd4, 8'h77));
        diag_write(9'o254, make_entry(3'd1, 3'd1, 8'hF0));
        run_lookup({9'o700, 4'h0});
        tests++; if (dram_valid !== 1'b1 || dram_a !== 3'd7 || dram_b !== 3'd1 || dram_j !== 8'hC3)
            begin fails++; $display("[TB] FAIL io_700 got=%b %0d/%0d/%h exp=1 7/1/c3", dram_valid, dram_a, dram_b, dram_j); end
        run_lookup({9'o774, 4'h0});
        tests++; if (dram_a !== 3'd4 || dram_j !== 8'h77)
            begin fails++; $display("[TB] FAIL io_fold got=%0d/%h exp=4/77", dram_a, dram_j); end
        run_lookup({9'o254, 4'h5});
        tests++; if (dram_j !== 8'hF5)
            begin fails++; $display("[TB] FAIL jrst_sub got=%h exp=f5", dram_j); end
        en_io_jrst = 0;
        run_lookup({9'o254, 4'h5});
        tests++; if (dram_j !== 8'hF0)
            begin fails++; $display("[TB] FAIL jrst_off got=%h exp=f0", dram_j); end
    endtask

    task automatic test_parity();
        diag_clr_err = 1;
        cycle();
        diag_clr_err = 0;
        diag_write(9'o123, make_entry(3'd2, 3'd2, 8'h33) ^ 15'h0100);
        run_lookup({9'o123, 4'h0});
        tests++; if (par_err !== 1'b1) begin fails++; $display("[TB] FAIL parity_set got=%b exp=1", par_err); end
        cycle(); cycle(); cycle();
        tests++; if (par_err !== 1'b1) begin fails++; $display("[TB] FAIL parity_sticky got=%b exp=1", par_err); end
        diag_clr_err = 1;
        cycle();
        diag_clr_err = 0;
        tests++; if (par_err !== 1'b0) begin fails++; $display("[TB] FAIL parity_clr got=%b exp=0", par_err); end
    endtask

    task automatic test_diag_collision();
        diag_write(9'o300, make_entry(3'd1, 3'd2, 8'h11));
        in_valid = 1; in_word = {9'o300, 4'h0};
        cycle();
        in_valid = 0; load_ir = 1;
        cycle();
        load_ir = 0;
        diag_write(9'o300, make_entry(3'd6, 3'd7, 8'h22));
        tests++; if (dram_valid !== 1'b0) begin fails++; $display("[TB] FAIL collide_delay got=%b exp=0", dram_valid); end
        cycle();
        tests++; if (dram_valid !== 1'b1 || dram_a !== 3'd6 || dram_b !== 3'd7 || dram_j !== 8'h22)
            begin fails++; $display("[TB] FAIL collide_data got=%b %0d/%0d/%h exp=1 6/7/22", dram_valid, dram_a, dram_b, dram_j); end
    endtask

    task automatic test_stall_flush();
        logic [12:0] ir_before;
        ir_before = ir;
        load_ir = 1;
        cycle();
        load_ir = 0;
        tests++; if (stall !== 1'b1 || ir !== ir_before)
            begin fails++; $display("[TB] FAIL stall_pulse got st=%b ir=%o exp st=1 ir=%o", stall, ir, ir_before); end
        cycle();
        tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL stall_clear got=%b exp=0", stall); end
        in_valid = 1; in_word = 13'o1234;
        cycle();
        in_word = 13'o4321;
        cycle();
        flush = 1; load_ir = 1; in_word = 13'o7777;
        cycle();
        flush = 0; load_ir = 0; in_valid = 0;
        tests++; if (q_count !== 3'd0 || dram_valid !== 1'b0 || ir !== ir_before)
            begin fails++; $display("[TB] FAIL flush got cnt=%0d dv=%b ir=%o exp 0 0 %o", q_count, dram_valid, ir, ir_before); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            in_valid     = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       in_word = {9'o254, 4'($urandom)};
                1:       in_word = {3'b111, 10'($urandom)};
                default: in_word = 13'($urandom);
            endcase
            load_ir      = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 29) == 0);
            diag_we      = ($urandom_range(0, 4) == 0);
            diag_addr    = ($urandom_range(0, 1) == 0) ? spec_addr(m_ir, en_io_jrst) : 9'($urandom);
            diag_wdata   = 15'($urandom);
            diag_clr_err = ($urandom_range(0, 9) == 0);
            en_io_jrst   = 1'($urandom);
            en_ac        = 1'($urandom);
            cycle();
            tests++; if (q_count !== 3'(m_q.size()) || in_ready !== (m_q.size() < 4))
                begin fails++; $display("[TB] FAIL rand_queue cyc=%0d got cnt=%0d rdy=%b exp cnt=%0d", c, q_count, in_ready, m_q.size()); end
            tests++; if (ir !== m_ir || ac !== m_ac || ir_valid !== m_irv)
                begin fails++; $display("[TB] FAIL rand_ir cyc=%0d got=%o/%h/%b exp=%o/%h/%b", c, ir, ac, ir_valid, m_ir, m_ac, m_irv); end
            tests++; if (stall !== m_stall || dram_valid !== m_dv || par_err !== m_perr)
                begin fails++; $display("[TB] FAIL rand_flags cyc=%0d got st=%b dv=%b pe=%b exp %b %b %b", c, stall, dram_valid, par_err, m_stall, m_dv, m_perr); end
            tests++; if (dram_a !== m_a || dram_b !== m_b || dram_j !== m_j)
                begin fails++; $display("[TB] FAIL rand_dram cyc=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", c, dram_a, dram_b, dram_j, m_a, m_b, m_j); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_lookup();
        test_fill_wrap();
        test_io_jrst();
        test_parity();
        test_diag_collision();
        test_stall_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
